// File: rtl/xio_bus_if.sv
// CPU parallel bus as seen by the xio_ctrl register block.
// The master drives the address, strobes and write data; the slave returns read data.
interface xio_bus_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] par_addr;
  logic              par_re;
  logic              par_we;
  logic [DATA_W-1:0] par_in;
  logic [DATA_W-1:0] par_out;

  modport master (output par_addr, par_re, par_we, par_in, input par_out);
  modport slave  (input par_addr, par_re, par_we, par_in, output par_out);
endinterface

// File: rtl/xio_ctrl.sv
// Memory-mapped I/O block: debounced buttons with sticky press flags, synced switches,
// LED register and seedable Galois LFSR. Define IO_IRQ_EN to add IRQ_MASK and the press irq.
module xio_ctrl #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 32,
  parameter int N_BTN      = 4,
  parameter int N_SW       = 7,
  parameter int N_LED      = 8,
  parameter int DEB_CYCLES = 500000,
  parameter int LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400
) (
  input  logic             clk,
  input  logic             rst,
  xio_bus_if.slave         bus,
  input  logic [N_BTN-1:0] btn,
  input  logic [N_SW-1:0]  sw,
  output logic [N_LED-1:0] leds,
  output logic             irq
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [N_BTN-1:0]  btn_s1_q, btn_s2_q;
  logic [N_SW-1:0]   sw_s1_q, sw_s2_q;
  logic [N_BTN-1:0]  deb_q, deb_d;
  logic [CNT_W-1:0]  cnt_q [N_BTN];
  logic [CNT_W-1:0]  cnt_d [N_BTN];
  logic [N_BTN-1:0]  press_q, press_d, rise;
  logic [N_LED-1:0]  led_q, led_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step, seed;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] rdata;
  logic              rd_press, wr_led, wr_lfsr;
  logic              unused_bits;

  assign rd_press  = bus.par_re && (bus.par_addr == ADDR_W'(1));
  assign wr_led    = bus.par_we && (bus.par_addr == ADDR_W'(3));
  assign wr_lfsr   = bus.par_we && (bus.par_addr == ADDR_W'(4));
  assign unused_bits = ^bus.par_in;

  // Debouncer: count consecutive cycles the synced value disagrees with the accepted state.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (btn_s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A new press on the read cycle survives the read-to-clear.
  assign rise    = deb_d & ~deb_q;
  assign press_d = rd_press ? rise : (press_q | rise);

  assign led_d     = wr_led ? bus.par_in[N_LED-1:0] : led_q;
  assign seed      = bus.par_in[LFSR_W-1:0];
  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);

  always_comb begin
    lfsr_d = lfsr_step;
    if (wr_lfsr) begin
      lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
    end
  end

`ifdef IO_IRQ_EN
  logic [N_BTN-1:0] mask_q, mask_d;
  logic             wr_mask;

  assign wr_mask = bus.par_we && (bus.par_addr == ADDR_W'(5));
  assign mask_d  = wr_mask ? bus.par_in[N_BTN-1:0] : mask_q;
  assign irq_d   = |(press_q & mask_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end
`else
  assign irq_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      deb_q    <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
      press_q  <= '0;
      led_q    <= '0;
      lfsr_q   <= LFSR_W'(1);
      irq_q    <= 1'b0;
    end else begin
      btn_s1_q <= btn;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      deb_q    <= deb_d;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
      press_q  <= press_d;
      led_q    <= led_d;
      lfsr_q   <= lfsr_d;
      irq_q    <= irq_d;
    end
  end

  // Read data depends only on the address so a read-with-write returns the pre-edge value.
  always_comb begin
    rdata = '0;
    case (bus.par_addr)
      ADDR_W'(0): rdata[N_BTN-1:0]  = deb_q;
      ADDR_W'(1): rdata[N_BTN-1:0]  = press_q;
      ADDR_W'(2): rdata[N_SW-1:0]   = sw_s2_q;
      ADDR_W'(3): rdata[N_LED-1:0]  = led_q;
      ADDR_W'(4): rdata[LFSR_W-1:0] = lfsr_q;
`ifdef IO_IRQ_EN
      ADDR_W'(5): rdata[N_BTN-1:0]  = mask_q;
`endif
      default:    rdata = '0;
    endcase
  end

  assign bus.par_out = rdata;
  assign leds        = led_q;
  assign irq         = irq_q;

endmodule
